// File: rtl/tbus_pkg.sv
// tbus_pkg: FSM state type and round-robin pick helper shared by the tristate-bus receiver.
package tbus_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  localparam int MAX_SRC = 32;
  function automatic int rr_pick(input logic [MAX_SRC-1:0] req, input int ptr, input int n);
    int sel;
    sel = 0;
    for (int k = n - 1; k >= 0; k--)
      if (req[(ptr + k) % n]) sel = (ptr + k) % n;
    return sel;
  endfunction
endpackage

// File: rtl/tbus_rr_arb.sv
// tbus_rr_arb: combinational round-robin picker, first set req at or after ptr (wrapping).
module tbus_rr_arb import tbus_pkg::*; #(
  parameter int NSRC = 4,
  localparam int IW = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NSRC-1:0] onehot,
  output logic [IW-1:0]   idx
);
  logic [MAX_SRC-1:0] req_w;
  int pick;
  always_comb begin
    req_w = '0;
    req_w[NSRC-1:0] = req;
    pick = rr_pick(req_w, int'(ptr), NSRC);
    idx = IW'(pick);
    onehot = (|req) ? NSRC'(1) << idx : '0;
  end
endmodule

// File: rtl/tbus_rx_ctrl.sv
// tbus_rx_ctrl: round-robin tristate-bus receiver with settle/turnaround timing; TBUS_PARITY_EN adds parity check.
module tbus_rx_ctrl import tbus_pkg::*; #(
  parameter int NSRC   = 4,
  parameter int W      = 8,
  parameter int SETTLE = 2,
  parameter int TURN   = 1,
  localparam int IW = $clog2(NSRC),
  localparam int CW = $clog2(SETTLE + TURN + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] req,
  output logic [NSRC-1:0] bus_en,
  input  logic [W-1:0]    bus_in,
`ifdef TBUS_PARITY_EN
  input  logic            bus_par,
  output logic            rx_perr,
`endif
  output logic [W-1:0]    rx_data,
  output logic [IW-1:0]   rx_src,
  output logic            rx_valid,
  input  logic            rx_ready
);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] ptr, ptr_n, sel, sel_n, pick_idx;
  logic [NSRC-1:0] bus_en_n, pick_oh;
  logic cap;
  tbus_rr_arb #(.NSRC(NSRC)) u_arb (.req(req), .ptr(ptr), .onehot(pick_oh), .idx(pick_idx));
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    bus_en_n = bus_en;
    ptr_n = ptr;
    sel_n = sel;
    cap = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (|req && !rx_valid) begin
          state_n = GRANT;
          bus_en_n = pick_oh;
          sel_n = pick_idx;
        end
      end
      GRANT:
        if (cnt == CW'(SETTLE - 1)) begin
          cap = 1'b1;
          bus_en_n = '0;
          ptr_n = (sel == IW'(NSRC - 1)) ? '0 : sel + IW'(1);
          state_n = tbus_pkg::TURN;
          cnt_n = '0;
        end
      tbus_pkg::TURN:
        if (cnt == CW'(TURN - 1)) begin
          state_n = IDLE;
          cnt_n = '0;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus_en <= '0;
      ptr <= '0;
      sel <= '0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_src <= '0;
`ifdef TBUS_PARITY_EN
      rx_perr <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bus_en <= bus_en_n;
      ptr <= ptr_n;
      sel <= sel_n;
      rx_valid <= cap | (rx_valid & ~rx_ready);
      if (cap) begin
        rx_data <= ~bus_in;
        rx_src <= sel;
`ifdef TBUS_PARITY_EN
        rx_perr <= ^(~bus_in) ^ ~bus_par;
`endif
      end
    end
  end
endmodule
